coffee_dispenser: RTL

- Downstream stage of the vending controller: consumes its `coffee` grant and runs a timed grind → brew → pour sequence on the actuators.
- Tracks the water-tank and bean-hopper inventory and returns `water` and `beans` to the vending controller, closing the loop.
- Flags requests that arrive with empty stock.

---
 rtl/coffee_dispenser.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/coffee_dispenser.sv
// rtl/coffee_dispenser.sv - timed grind/brew/pour sequencer with water and bean inventory
module coffee_dispenser #(
    parameter int GRIND_CYC = 4,
    parameter int BREW_CYC  = 8,
    parameter int POUR_CYC  = 6,
    parameter int WATER_MAX = 31,
    parameter int BEAN_MAX  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coffee,
    input  logic       refill_water,
    input  logic       refill_beans,
    output logic [4:0] water,
    output logic       beans,
    output logic       grinder,
    output logic       heater,
    output logic       pump,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRIND = 3'd1,
        BREW  = 3'd2,
        POUR  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] GRIND_LAST = 8'(GRIND_CYC - 1);
    localparam logic [7:0] BREW_LAST  = 8'(BREW_CYC - 1);
    localparam logic [7:0] POUR_LAST  = 8'(POUR_CYC - 1);
    localparam logic [4:0] W_MAX      = 5'(WATER_MAX);
    localparam logic [3:0] B_MAX      = 4'(BEAN_MAX);

    state_t     state_q, state_d;
    logic [7:0] ph_q, ph_d;
    logic       coffee_q;
    logic [4:0] water_q, water_d;
    logic [3:0] bean_cnt_q, bean_cnt_d;
    logic       fault_q, fault_d;
    logic       grinder_q, grinder_d;
    logic       heater_q, heater_d;
    logic       pump_q, pump_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       req;
    logic       bean_dec;
    logic       water_dec;

    always_comb begin
        req       = coffee & ~coffee_q;
        state_d   = state_q;
        ph_d      = ph_q;
        bean_dec  = 1'b0;
        water_dec = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (water_q != 5'd0 && bean_cnt_q != 4'd0) begin
                        state_d = GRIND;
                        ph_d    = 8'd0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            GRIND: begin
                if (ph_q == GRIND_LAST) begin
                    state_d  = BREW;
                    ph_d     = 8'd0;
                    bean_dec = 1'b1;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            BREW: begin
                if (ph_q == BREW_LAST) begin
                    state_d = POUR;
                    ph_d    = 8'd0;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            POUR: begin
                if (ph_q == POUR_LAST) begin
                    state_d   = DONE;
                    ph_d      = 8'd0;
                    water_dec = 1'b1;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Refill wins over a same-cycle decrement; decrements saturate at zero.
        if (refill_water)
            water_d = W_MAX;
        else if (water_dec && water_q != 5'd0)
            water_d = water_q - 5'd1;
        else
            water_d = water_q;

        if (refill_beans)
            bean_cnt_d = B_MAX;
        else if (bean_dec && bean_cnt_q != 4'd0)
            bean_cnt_d = bean_cnt_q - 4'd1;
        else
            bean_cnt_d = bean_cnt_q;

        // Outputs are registered decodes of the next state, so they track state_q exactly.
        grinder_d = (state_d == GRIND);
        heater_d  = (state_d == BREW);
        pump_d    = (state_d == POUR);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ph_q       <= 8'd0;
            coffee_q   <= 1'b0;
            water_q    <= W_MAX;
            bean_cnt_q <= B_MAX;
            fault_q    <= 1'b0;
            grinder_q  <= 1'b0;
            heater_q   <= 1'b0;
            pump_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            coffee_q   <= coffee;
            water_q    <= water_d;
            bean_cnt_q <= bean_cnt_d;
            fault_q    <= fault_d;
            grinder_q  <= grinder_d;
            heater_q   <= heater_d;
            pump_q     <= pump_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign water   = water_q;
    assign beans   = (bean_cnt_q != 4'd0);
    assign grinder = grinder_q;
    assign heater  = heater_q;
    assign pump    = pump_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fault   = fault_q;

endmodule
